// File: rtl/gv_pkg.sv
// Shared types and default sizing for the push-button conditioner.
package gv_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } ch_state_e;

  localparam int N_BTN_DEF     = 21;
  localparam int DB_CYCLES_DEF = 120000;

endpackage

// File: rtl/pb_debounce_ch.sv
// One push-button channel: 2-flop synchronizer, debounce FSM and window counter.
//
// state        | meaning
// IDLE         | button released and stable
// PRESS_WAIT   | sync went high, counting stable-high cycles
// PRESSED      | debounced press, level held high
// RELEASE_WAIT | sync went low, counting stable-low cycles
module pb_debounce_ch
  import gv_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_raw_i,
  output logic pb_level_o,
  output logic pb_press_o,
  output logic pb_release_o
);

  localparam int              CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);

  logic          meta_q, sync_q;
  ch_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      meta_q    <= pb_raw_i;
      sync_q    <= meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Level is registered alongside the state so it tracks PRESSED/RELEASE_WAIT exactly.
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  assign pb_level_o   = level_q;
  assign pb_press_o   = press_q;
  assign pb_release_o = release_q;

endmodule

// File: rtl/pb_conditioner.sv
// Bank of N_BTN independent debounced push-button channels with press/release strobes.
module pb_conditioner
  import gv_pkg::*;
#(
  parameter int N_BTN     = N_BTN_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] pb_raw,
  output logic [N_BTN-1:0] pb_level,
  output logic [N_BTN-1:0] pb_press,
  output logic [N_BTN-1:0] pb_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    pb_debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .pb_raw_i    (pb_raw[i]),
      .pb_level_o  (pb_level[i]),
      .pb_press_o  (pb_press[i]),
      .pb_release_o(pb_release[i])
    );
  end

endmodule

// File: tb/tb_pb_conditioner.sv
// Self-checking bench for pb_conditioner with N_BTN=5, DB_CYCLES=4.
module tb_pb_conditioner;

  localparam int N  = 5;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pb_raw;
  logic [N-1:0] pb_level, pb_press, pb_release;

  always #5 clk = ~clk;

  pb_conditioner #(.N_BTN(N), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .pb_raw    (pb_raw),
    .pb_level  (pb_level),
    .pb_press  (pb_press),
    .pb_release(pb_release)
  );

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference: level flips once the synchronized input has disagreed with it for DB+1 edges.
  logic [N-1:0] m_s1, m_s2, m_lvl;
  int           m_run[N];

  task automatic tick(input logic r, input logic [N-1:0] raw);
    exp_t e;
    e.prs = '0;
    e.rel = '0;
    if (r) begin
      m_s1  = '0;
      m_s2  = '0;
      m_lvl = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_lvl[i] = ~m_lvl[i];
            if (m_lvl[i]) e.prs[i] = 1'b1;
            else          e.rel[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
    e.lvl = m_lvl;
    sb.push_back(e);
    rst    = r;
    pb_raw = raw;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] raw);
    exp_t e;
    tick(1'b1, raw);
    tick(1'b1, raw);
    e = sb.pop_front();
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, '1);
      e = sb.pop_front();
      total++;
      if ({pb_level, pb_press, pb_release} !== e) begin
        bad++;
        $display("FAIL reset_sb k=%0d got=%h exp=%h", k, {pb_level, pb_press, pb_release}, e);
      end
      total++;
      if ({pb_level, pb_press, pb_release} !== '0) begin
        bad++;
        $display("FAIL reset_zero k=%0d got=%h exp=0", k, {pb_level, pb_press, pb_release});
      end
    end
  endtask

  task automatic test_press();
    exp_t e;
    do_reset('0);
    for (int k = 1; k <= 10; k++) begin
      tick(1'b0, 5'b01000);
      e = sb.pop_front();
      total++;
      if ({pb_level, pb_press, pb_release} !== e) begin
        bad++;
        $display("FAIL press_sb k=%0d got=%h exp=%h", k, {pb_level, pb_press, pb_release}, e);
      end
      if (k == 6 || k == 7 || k == 8) begin
        total++;
        if (pb_press !== ((k == 7) ? 5'b01000 : 5'b00000) ||
            pb_level !== ((k >= 7) ? 5'b01000 : 5'b00000)) begin
          bad++;
          $display("FAIL press_latency k=%0d press=%b level=%b", k, pb_press, pb_level);
        end
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, (k <= 2 || k > 10) ? 5'b00000 : 5'b01000);
      e = sb.pop_front();
      total++;
      if ({pb_level, pb_press, pb_release} !== e) begin
        bad++;
        $display("FAIL glitch_sb k=%0d got=%h exp=%h", k, {pb_level, pb_press, pb_release}, e);
      end
      if (k <= 10) begin
        total++;
        if (pb_release[3] !== 1'b0 || pb_level[3] !== 1'b1) begin
          bad++;
          $display("FAIL glitch_hold k=%0d rel=%b level=%b exp rel=0 level=1", k, pb_release[3], pb_level[3]);
        end
      end
      if (k == 16 || k == 17) begin
        total++;
        if (pb_release !== ((k == 17) ? 5'b01000 : 5'b00000) ||
            pb_level !== ((k == 17) ? 5'b00000 : 5'b01000)) begin
          bad++;
          $display("FAIL release_latency k=%0d rel=%b level=%b", k, pb_release, pb_level);
        end
      end
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    for (int k = 1; k <= 18; k++) begin
      tick(1'b0, (k <= 3 || k > 11) ? 5'b10000 : 5'b00000);
      e = sb.pop_front();
      total++;
      if ({pb_level, pb_press, pb_release} !== e) begin
        bad++;
        $display("FAIL bounce_sb k=%0d got=%h exp=%h", k, {pb_level, pb_press, pb_release}, e);
      end
      if (k <= 11) begin
        total++;
        if (pb_press[4] !== 1'b0 || pb_level[4] !== 1'b0) begin
          bad++;
          $display("FAIL bounce_reject k=%0d press=%b level=%b exp 0", k, pb_press[4], pb_level[4]);
        end
      end
      if (k == 17 || k == 18) begin
        total++;
        if (pb_press[4] !== (k == 18)) begin
          bad++;
          $display("FAIL bounce_idle k=%0d press=%b exp=%b", k, pb_press[4], (k == 18));
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    do_reset('0);
    for (int k = 1; k <= 9; k++) begin
      tick(1'b0, 5'b01111);
      e = sb.pop_front();
      total++;
      if ({pb_level, pb_press, pb_release} !== e) begin
        bad++;
        $display("FAIL simul_sb k=%0d got=%h exp=%h", k, {pb_level, pb_press, pb_release}, e);
      end
      if (k == 7 || k == 8) begin
        total++;
        if (pb_press !== ((k == 7) ? 5'b01111 : 5'b00000) || pb_level !== 5'b01111) begin
          bad++;
          $display("FAIL simul_press k=%0d press=%b level=%b", k, pb_press, pb_level);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset('0);
    for (int k = 1; k <= 15; k++) begin
      tick((k == 5 || k == 6), 5'b00001);
      e = sb.pop_front();
      total++;
      if ({pb_level, pb_press, pb_release} !== e) begin
        bad++;
        $display("FAIL rstmid_sb k=%0d got=%h exp=%h", k, {pb_level, pb_press, pb_release}, e);
      end
      total++;
      if (pb_press !== ((k == 13) ? 5'b00001 : 5'b00000)) begin
        bad++;
        $display("FAIL rstmid_press k=%0d press=%b exp=%b", k, pb_press, (k == 13) ? 5'b00001 : 5'b00000);
      end
    end
  endtask

  task automatic test_soak();
    exp_t         e;
    logic [N-1:0] raw;
    int           n_prs[N];
    int           n_rel[N];
    int           diff;
    raw = '0;
    for (int i = 0; i < N; i++) begin
      n_prs[i] = 0;
      n_rel[i] = 0;
    end
    do_reset('0);
    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(5, 0) == 0) raw[i] = ~raw[i];
      tick(1'b0, raw);
      e = sb.pop_front();
      total++;
      if ({pb_level, pb_press, pb_release} !== e) begin
        bad++;
        $display("FAIL soak_sb k=%0d got=%h exp=%h", k, {pb_level, pb_press, pb_release}, e);
      end
      for (int i = 0; i < N; i++) begin
        if (pb_press[i] === 1'b1) begin
          total++;
          if (n_prs[i] != n_rel[i] || pb_release[i] !== 1'b0) begin
            bad++;
            $display("FAIL soak_alt_press ch=%0d presses=%0d releases=%0d", i, n_prs[i], n_rel[i]);
          end
          n_prs[i]++;
        end
        if (pb_release[i] === 1'b1) begin
          total++;
          if (n_prs[i] != n_rel[i] + 1) begin
            bad++;
            $display("FAIL soak_alt_release ch=%0d presses=%0d releases=%0d", i, n_prs[i], n_rel[i]);
          end
          n_rel[i]++;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      diff = n_prs[i] - n_rel[i];
      total++;
      if (diff < 0 || diff > 1 || n_prs[i] == 0) begin
        bad++;
        $display("FAIL soak_count ch=%0d presses=%0d releases=%0d need diff 0..1 and presses>0",
                 i, n_prs[i], n_rel[i]);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    pb_raw = '0;
    test_reset();
    test_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pb_conditioner.md
PB_CONDITIONER -- requirements
Module: pb_conditioner

Interface
REQ-001 The block SHALL have parameter N_BTN, default 21: number of push-button channels, range 1..32.
REQ-002 The block SHALL have parameter DB_CYCLES, default 120000: debounce stability window in clk cycles (10 ms at 12 MHz), minimum 2.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port pb_raw, input, N_BTN bits: asynchronous, bouncing push-button levels, 1 = pressed.
REQ-006 The block SHALL have port pb_level, output, N_BTN bits: debounced button level, 1 = pressed.
REQ-007 The block SHALL have port pb_press, output, N_BTN bits: one-cycle pulse per debounced press; these are the pushed_* strobes consumed by the game state FSM.
REQ-008 The block SHALL have port pb_release, output, N_BTN bits: one-cycle pulse per debounced release.
REQ-009 The block SHALL drive all outputs from registers, with no combinational path from pb_raw to any output.

Function
REQ-010 Each channel SHALL pass pb_raw[i] through a 2-flop synchronizer; the second-flop output is "sync".
REQ-011 Each channel SHALL run an independent FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a debounce counter of ceil(log2(DB_CYCLES)) bits.
REQ-012 In IDLE with sync=1, the channel SHALL go to PRESS_WAIT with cnt=0; with sync=0 it SHALL stay in IDLE.
REQ-013 In PRESS_WAIT with sync=0, the channel SHALL return to IDLE with no pulse (bounce rejected).
REQ-014 In PRESS_WAIT with sync=1 and cnt<DB_CYCLES-1, the channel SHALL increment cnt.
REQ-015 In PRESS_WAIT with sync=1 and cnt=DB_CYCLES-1, the channel SHALL go to PRESSED, set pb_level=1 and assert pb_press for exactly one cycle.
REQ-016 In PRESSED with sync=0, the channel SHALL go to RELEASE_WAIT with cnt=0; with sync=1 it SHALL stay in PRESSED.
REQ-017 In RELEASE_WAIT with sync=1, the channel SHALL return to PRESSED with no pulse, and pb_level SHALL stay 1.
REQ-018 In RELEASE_WAIT with sync=0 and cnt=DB_CYCLES-1, the channel SHALL go to IDLE, clear pb_level and assert pb_release for one cycle; otherwise it SHALL increment cnt.
REQ-019 pb_level SHALL be 1 exactly in states PRESSED and RELEASE_WAIT.
REQ-020 Press latency: when pb_raw[i] is stable high from clock edge 1, pb_level and pb_press SHALL become visible after edge DB_CYCLES+3; release latency SHALL be symmetric.
REQ-021 Every channel SHALL produce at most one pb_press per debounced press and at most one pb_release per debounced release, with press and release alternating strictly.
REQ-022 Channels SHALL be fully independent: simultaneous events on any subset of channels SHALL each produce their own pulses in the same cycle.
REQ-023 The counter SHALL never wrap, because it is cleared on every state entry and bounded by DB_CYCLES-1.

Reset
REQ-024 When rst=1 at a clock edge, all synchronizer flops, counters, pb_level, pb_press and pb_release SHALL be cleared to 0 and all FSMs SHALL go to IDLE.
REQ-025 Reset asserted mid-debounce SHALL abort the debounce, and no pulse SHALL be emitted.
REQ-026 A button held through reset deassertion SHALL be treated as a new press: it runs the full window and emits one pb_press.

Structure
REQ-027 The shared package gv_pkg SHALL hold the channel-state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) and the default constants N_BTN_DEF=21 and DB_CYCLES_DEF=120000.
REQ-028 The per-channel logic SHALL be the sub-module pb_debounce_ch (synchronizer, FSM and counter); pb_conditioner SHALL generate N_BTN instances of it.

Verification (N_BTN=5, DB_CYCLES=4)
REQ-029 Bench SHALL cover: rst, then pb_raw[3] held high -> pb_press[3] high for exactly 1 cycle after edge 7, pb_level[3]=1 from then on, other bits 0.
REQ-030 Bench SHALL cover: pb_raw[4] high for 3 cycles then low -> no pb_press[4], pb_level[4] stays 0, FSM back in IDLE.
REQ-031 Bench SHALL cover: pressed channel 3 with pb_raw[3] dropping for 2 cycles -> no pb_release[3], pb_level[3] stays 1.
REQ-032 Bench SHALL cover: pb_raw[3:0] rising on the same edge -> pb_press=4'hF in a single cycle, then pulses 0.
REQ-033 Bench SHALL cover: rst pulsed in PRESS_WAIT with button still held -> no pulse during reset, then one pb_press 7 edges after rst deasserts.
REQ-034 Bench SHALL cover: a 1000-cycle random-bounce soak -> counts of pb_press and pb_release per channel differ by at most 1, with strict alternation.
